// File: rtl/vma_diag_pkg.sv
// vma_diag_pkg: shared types and EBUS read-back routing for the VMA diag reader.
// Exports state_e, word_e, dst_t, flag slots, EBUS_BIT/EBUS_MASK and map_dst().
package vma_diag_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        W_PC,
        W_HELD,
        W_VMA,
        W_BRK,
        W_PSEC,
        W_FLAG
    } word_e;

    localparam int NBITS = 13;

    // EBUS lines the VMA board drives, slot k -> bit 11+2k
    localparam int EBUS_BIT [NBITS] = '{
        11, 13, 15, 17, 19, 21, 23,
        25, 27, 29, 31, 33, 35
    };

    // Flag slots inside the shadow flag vector
    localparam int F_VSEC0  = 0;
    localparam int F_PCSEC0 = 1;
    localparam int F_PCSSEC = 2;
    localparam int F_MISC   = 3;
    localparam int F_ACREF  = 4;
    localparam int F_LAC    = 5;
    localparam int F_MATCH  = 6;

    typedef struct packed {
        word_e      word;
        logic [5:0] idx;
        logic       inv;
    } dst_t;

    function automatic logic [0:35] ebus_mask();
        logic [0:35] m;
        m = '0;
        for (int k = 0; k < NBITS; k++) begin
            m[EBUS_BIT[k]] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [0:35] EBUS_MASK = ebus_mask();

    // Where EBUS slot k lands for select code s; inv marks low-true flags.
    function automatic dst_t map_dst(input int k, input logic [2:0] s);
        dst_t d;
        int   e;
        int   b;
        int   si;
        logic pcside;
        d      = '{word: W_FLAG, idx: 6'd0, inv: 1'b0};
        si     = int'(s);
        e      = EBUS_BIT[k];
        pcside = (k == 1);
        b      = 0;
        if (k == 0) begin
            if (si >= 5) begin
                // s7..5 -> vma_sec0, pc_sec0, pcs_sec0
                d.idx = 6'(7 - si);
                d.inv = 1'b1;
            end else begin
                d.word = W_PSEC;
                d.idx  = 6'(17 - si);
            end
        end else if (k <= 2) begin
            if (si >= 5) begin
                d.word = pcside ? W_PC : W_BRK;
                d.idx  = 6'(20 - si);
            end else if (si == 4) begin
                d.idx = pcside ? 6'(F_MISC) : 6'(F_LAC);
                d.inv = 1'b1;
            end else if (si >= 1) begin
                d.word = pcside ? W_HELD : W_VMA;
                d.idx  = 6'(16 - si);
            end else begin
                d.idx = pcside ? 6'(F_ACREF) : 6'(F_MATCH);
                d.inv = 1'b1;
            end
        end else begin
            // b+1 lines carry PC/HELD, b+3 lines carry ADR_BRK/VMA
            pcside = (e % 4 == 1);
            b      = pcside ? e - 1 : e - 3;
            if (s[2]) begin
                d.word = pcside ? W_PC : W_BRK;
            end else begin
                d.word = pcside ? W_HELD : W_VMA;
            end
            d.idx = 6'(b + 3 - int'(s[1:0]));
        end
        return d;
    endfunction

endpackage

// File: rtl/vma_diag_shadow.sv
// vma_diag_shadow: capture bank that scatters one EBUS sample per select code
// into shadow words; copy publishes the bank (including a same-cycle capture).
import vma_diag_pkg::*;

module vma_diag_shadow (
    input  logic             clk,
    input  logic             reset,
    input  logic             cap,
    input  logic             copy,
    input  logic [2:0]       sel,
    input  logic [NBITS-1:0] bits,
    output logic [13:35]     pc,
    output logic [13:35]     held,
    output logic [13:35]     vma,
    output logic [13:35]     adr_brk,
    output logic [13:17]     prev_sec,
    output logic [6:0]       flags
);

    logic [13:35] sh_pc, sh_held, sh_vma, sh_brk;
    logic [13:35] nx_pc, nx_held, nx_vma, nx_brk;
    logic [13:17] sh_ps, nx_ps;
    logic [6:0]   sh_fl, nx_fl;
    dst_t         d;
    logic         v;

    always_comb begin
        nx_pc   = sh_pc;
        nx_held = sh_held;
        nx_vma  = sh_vma;
        nx_brk  = sh_brk;
        nx_ps   = sh_ps;
        nx_fl   = sh_fl;
        d       = '0;
        v       = 1'b0;
        if (cap) begin
            for (int k = 0; k < NBITS; k++) begin
                d = map_dst(k, sel);
                v = bits[k] ^ d.inv;
                unique case (d.word)
                    W_PC:    nx_pc[d.idx]        = v;
                    W_HELD:  nx_held[d.idx]      = v;
                    W_VMA:   nx_vma[d.idx]       = v;
                    W_BRK:   nx_brk[d.idx]       = v;
                    W_PSEC:  nx_ps[d.idx[4:0]]   = v;
                    W_FLAG:  nx_fl[d.idx[2:0]]   = v;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_pc    <= '0;
            sh_held  <= '0;
            sh_vma   <= '0;
            sh_brk   <= '0;
            sh_ps    <= '0;
            sh_fl    <= '0;
            pc       <= '0;
            held     <= '0;
            vma      <= '0;
            adr_brk  <= '0;
            prev_sec <= '0;
            flags    <= '0;
        end else begin
            sh_pc   <= nx_pc;
            sh_held <= nx_held;
            sh_vma  <= nx_vma;
            sh_brk  <= nx_brk;
            sh_ps   <= nx_ps;
            sh_fl   <= nx_fl;
            if (copy) begin
                pc       <= nx_pc;
                held     <= nx_held;
                vma      <= nx_vma;
                adr_brk  <= nx_brk;
                prev_sec <= nx_ps;
                flags    <= nx_fl;
            end
        end
    end

endmodule

// File: rtl/vma_diag_reader.sv
// vma_diag_reader: walks diag select 7..0 with DIAG READ FUNC 15x held high,
// samples EBUS after settling and publishes PC/HELD/VMA/ADR_BRK/PREV_SEC/flags.
import vma_diag_pkg::*;

module vma_diag_reader #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [0:35]  ebus_data,
    output logic         read_func,
    output logic [4:6]   diag_sel,
    output logic         busy,
    output logic         done,
    output logic [13:35] pc,
    output logic [13:35] held,
    output logic [13:35] vma,
    output logic [13:35] adr_brk,
    output logic [13:17] prev_sec,
    output logic         misc_nz,
    output logic         ac_ref,
    output logic         local_ac,
    output logic         match,
    output logic         vma_sec0,
    output logic         pc_sec0,
    output logic         pcs_sec0
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e           state, state_nx;
    logic [2:0]       sel, sel_nx;
    logic [3:0]       cnt, cnt_nx;
    logic             cap, copy;
    logic [NBITS-1:0] bits;
    logic [6:0]       flags;
    logic             unused_bus;

    for (genvar k = 0; k < NBITS; k++) begin : g_tap
        assign bits[k] = ebus_data[EBUS_BIT[k]];
    end

    assign unused_bus = ^(ebus_data & ~EBUS_MASK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = DRIVE;
                    sel_nx   = 3'd7;
                end
            end
            DRIVE: begin
                cnt_nx   = CNT_LOAD;
                state_nx = SETTLE;
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nx = SAMPLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            SAMPLE: begin
                if (sel == 3'd0) begin
                    state_nx = DONE;
                end else begin
                    sel_nx   = sel - 3'd1;
                    state_nx = DRIVE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) begin
            state_nx = IDLE;
        end
    end

    // The final sample and the publish share one edge, so done and
    // the new results appear together.
    always_comb begin
        read_func = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        cap       = 1'b0;
        copy      = 1'b0;
        unique case (state)
            DRIVE, SETTLE: begin
                read_func = 1'b1;
                busy      = 1'b1;
            end
            SAMPLE: begin
                read_func = 1'b1;
                busy      = 1'b1;
                cap       = !abort;
                copy      = !abort && (sel == 3'd0);
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign diag_sel = read_func ? sel : 3'd0;

    vma_diag_shadow u_shadow (
        .clk      (clk),
        .reset    (reset),
        .cap      (cap),
        .copy     (copy),
        .sel      (sel),
        .bits     (bits),
        .pc       (pc),
        .held     (held),
        .vma      (vma),
        .adr_brk  (adr_brk),
        .prev_sec (prev_sec),
        .flags    (flags)
    );

    assign vma_sec0 = flags[F_VSEC0];
    assign pc_sec0  = flags[F_PCSEC0];
    assign pcs_sec0 = flags[F_PCSSEC];
    assign misc_nz  = flags[F_MISC];
    assign ac_ref   = flags[F_ACREF];
    assign local_ac = flags[F_LAC];
    assign match    = flags[F_MATCH];

endmodule

// File: tb/tb_vma_diag_reader.sv
// tb_vma_diag_reader: VMA-board model driving EBUS from diag_sel, scoreboard
// of expected snapshots checked by done-driven monitors on two builds.
module tb_vma_diag_reader;

    typedef struct packed {
        logic [13:35] pc;
        logic [13:35] held;
        logic [13:35] vma;
        logic [13:35] brk;
        logic [13:17] ps;
        // 6 match,5 local_ac,4 ac_ref,3 misc_nz,2 pcs_sec0,1 pc_sec0,0 vma_sec0
        logic [6:0]   fl;
    } snap_t;

    typedef struct {
        snap_t s;
        int    cyc;
    } exp_t;

    localparam snap_t S1 = '{pc: 23'o1234567, held: 23'o7654321,
                             vma: 23'o0000777, brk: 23'o3333333,
                             ps: 5'b10110, fl: 7'b0101101};
    localparam snap_t S2 = '{pc: 23'h5a5a5a, held: 23'h2c3d4e,
                             vma: 23'h7fffff, brk: 23'h400001,
                             ps: 5'b01001, fl: 7'b1010010};
    localparam snap_t S3 = '{pc: 23'h012345, held: 23'h654321,
                             vma: 23'h111111, brk: 23'h222222,
                             ps: 5'b11111, fl: 7'b1111111};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, abort_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0;
    logic [0:35] ebus_a, ebus_b;

    logic rf_a, busy_a, done_a, rf_b, busy_b, done_b;
    logic [4:6] sel_a, sel_b;
    logic [13:35] pc_a, held_a, vma_a, brk_a;
    logic [13:35] pc_b, held_b, vma_b, brk_b;
    logic [13:17] ps_a, ps_b;
    logic mz_a, ar_a, la_a, mt_a, vs_a, ps0_a, pcs_a;
    logic mz_b, ar_b, la_b, mt_b, vs_b, ps0_b, pcs_b;

    snap_t out_a, out_b;
    snap_t m_a = '0;
    snap_t m_b = '0;
    logic [3:0] last_a, last_b;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int n_done_a = 0;
    int n_done_b = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    vma_diag_reader dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .ebus_data(ebus_a), .read_func(rf_a), .diag_sel(sel_a),
        .busy(busy_a), .done(done_a), .pc(pc_a), .held(held_a),
        .vma(vma_a), .adr_brk(brk_a), .prev_sec(ps_a),
        .misc_nz(mz_a), .ac_ref(ar_a), .local_ac(la_a), .match(mt_a),
        .vma_sec0(vs_a), .pc_sec0(ps0_a), .pcs_sec0(pcs_a)
    );

    vma_diag_reader #(.SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .ebus_data(ebus_b), .read_func(rf_b), .diag_sel(sel_b),
        .busy(busy_b), .done(done_b), .pc(pc_b), .held(held_b),
        .vma(vma_b), .adr_brk(brk_b), .prev_sec(ps_b),
        .misc_nz(mz_b), .ac_ref(ar_b), .local_ac(la_b), .match(mt_b),
        .vma_sec0(vs_b), .pc_sec0(ps0_b), .pcs_sec0(pcs_b)
    );

    assign out_a = {pc_a, held_a, vma_a, brk_a, ps_a,
                    mt_a, la_a, ar_a, mz_a, pcs_a, ps0_a, vs_a};
    assign out_b = {pc_b, held_b, vma_b, brk_b, ps_b,
                    mt_b, la_b, ar_b, mz_b, pcs_b, ps0_b, vs_b};

    // VMA board read-back table, one select code at a time
    function automatic logic [0:35] ebus_of(snap_t m, logic [2:0] s);
        logic [0:35] e;
        int si;
        int b;
        e  = '1;
        si = int'(s);
        for (int i = 0; i < 5; i++) begin
            b = 16 + 4 * i;
            if (si >= 4) begin
                e[b+1] = m.pc[6'(b + 7 - si)];
                e[b+3] = m.brk[6'(b + 7 - si)];
            end else begin
                e[b+1] = m.held[6'(b + 3 - si)];
                e[b+3] = m.vma[6'(b + 3 - si)];
            end
        end
        case (si)
            7: begin e[13] = m.pc[13]; e[15] = m.brk[13]; e[11] = ~m.fl[0]; end
            6: begin e[13] = m.pc[14]; e[15] = m.brk[14]; e[11] = ~m.fl[1]; end
            5: begin e[13] = m.pc[15]; e[15] = m.brk[15]; e[11] = ~m.fl[2]; end
            4: begin e[13] = ~m.fl[3]; e[15] = ~m.fl[5]; e[11] = m.ps[13]; end
            3: begin e[13] = m.held[13]; e[15] = m.vma[13]; e[11] = m.ps[14]; end
            2: begin e[13] = m.held[14]; e[15] = m.vma[14]; e[11] = m.ps[15]; end
            1: begin e[13] = m.held[15]; e[15] = m.vma[15]; e[11] = m.ps[16]; end
            default: begin e[13] = ~m.fl[4]; e[15] = ~m.fl[6]; e[11] = m.ps[17]; end
        endcase
        return e;
    endfunction

    // Bus shows inverted data on the clock the select changes (not settled)
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            last_a <= '0;
            last_b <= '0;
        end else begin
            last_a <= {rf_a, sel_a};
            last_b <= {rf_b, sel_b};
        end
    end

    always_comb begin
        ebus_a = '1;
        if (rf_a) begin
            ebus_a = ebus_of(m_a, sel_a);
            if ({rf_a, sel_a} != last_a) ebus_a = ~ebus_a;
        end
    end

    always_comb begin
        ebus_b = '1;
        if (rf_b) begin
            ebus_b = ebus_of(m_b, sel_b);
            if ({rf_b, sel_b} != last_b) ebus_b = ~ebus_b;
        end
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_snap(input string tag, input snap_t act,
                            input exp_t e);
        chk({tag, "_pc"}, act.pc, e.s.pc);
        chk({tag, "_held"}, act.held, e.s.held);
        chk({tag, "_vma"}, act.vma, e.s.vma);
        chk({tag, "_brk"}, act.brk, e.s.brk);
        chk({tag, "_prev_sec"}, act.ps, e.s.ps);
        chk({tag, "_flags"}, act.fl, e.s.fl);
        chk({tag, "_latency"}, cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        if (done_a) begin
            n_done_a++;
            chk("a_done_expected", qa.size() != 0, 1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                cmp_snap("a", out_a, ea);
            end
        end
        if (done_b) begin
            n_done_b++;
            chk("b_done_expected", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                cmp_snap("b", out_b, eb);
            end
        end
    end

    task automatic push_a(input snap_t s, input int c);
        exp_t e;
        e.s = s;
        e.cyc = c;
        qa.push_back(e);
    endtask

    task automatic push_b(input snap_t s, input int c);
        exp_t e;
        e.s = s;
        e.cyc = c;
        qb.push_back(e);
    endtask

    task automatic pulse_a(output int t0);
        @(negedge clk);
        start_a = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic pulse_b(output int t0);
        @(negedge clk);
        start_b = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nd;
        #1;
        chk("rst_busy_a", busy_a, 0);
        chk("rst_rf_a", rf_a, 0);
        chk("rst_sel_a", sel_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_snap_a", out_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_snap_b", out_b, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // full snapshot, flag decode
        m_a = S1;
        nd = n_done_a;
        pulse_a(t0);
        push_a(S1, t0 + 33);
        chk("t1_busy", busy_a, 1);
        chk("t1_rf", rf_a, 1);
        chk("t1_sel", sel_a, 7);
        repeat (40) @(negedge clk);
        chk("t1_ndone", n_done_a - nd, 1);
        chk("t1_hold", out_a, S1);
        chk("t1_idle", busy_a, 0);

        // start while busy is ignored
        m_a = S2;
        nd = n_done_a;
        pulse_a(t0);
        push_a(S2, t0 + 33);
        repeat (8) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (40) @(negedge clk);
        chk("t2_ndone", n_done_a - nd, 1);
        chk("t2_hold", out_a, S2);

        // abort mid-snapshot keeps previous results
        m_a = S3;
        nd = n_done_a;
        pulse_a(t0);
        repeat (13) @(negedge clk);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("t3_busy", busy_a, 0);
        chk("t3_rf", rf_a, 0);
        chk("t3_done", done_a, 0);
        repeat (40) @(negedge clk);
        chk("t3_ndone", n_done_a - nd, 0);
        chk("t3_hold", out_a, S2);

        // abort beats start from idle
        @(negedge clk);
        start_a = 1'b1;
        abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("t3b_busy", busy_a, 0);
        chk("t3b_rf", rf_a, 0);
        repeat (40) @(negedge clk);
        chk("t3b_ndone", n_done_a - nd, 0);

        // async reset mid-snapshot, then a clean snapshot
        m_a = S1;
        pulse_a(t0);
        push_a(S1, t0 + 33);
        repeat (19) @(negedge clk);
        #2;
        reset = 1'b1;
        qa.delete();
        #1;
        chk("t4_busy", busy_a, 0);
        chk("t4_rf", rf_a, 0);
        chk("t4_sel", sel_a, 0);
        chk("t4_done", done_a, 0);
        chk("t4_snap", out_a, 0);
        #1;
        reset = 1'b0;
        m_a = S3;
        nd = n_done_a;
        pulse_a(t0);
        push_a(S3, t0 + 33);
        repeat (40) @(negedge clk);
        chk("t4_ndone", n_done_a - nd, 1);
        chk("t4_hold", out_a, S3);

        // SETTLE_CYCLES=1 build: select walk and 25-clock latency
        m_b = S2;
        nd = n_done_b;
        pulse_b(t0);
        push_b(S2, t0 + 25);
        for (int j = 1; j <= 24; j++) begin
            chk($sformatf("b_rf_%0d", j), rf_b, 1);
            chk($sformatf("b_sel_%0d", j), sel_b, 7 - (j - 1) / 3);
            @(negedge clk);
        end
        chk("b_done_at_25", done_b, 1);
        chk("b_rf_low", rf_b, 0);
        repeat (3) @(negedge clk);
        chk("b_ndone", n_done_b - nd, 1);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
